// File: rtl/multicycle_control_if.sv
// ============================================================================
//  Module      : multicycle_control_if
//  Description : Opcode input and datapath control strobes of the
//                multi-cycle processor controller.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface multicycle_control_if;
    logic [5:0] Op;
    logic       PCWrite;
    logic       PCWriteCond;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       MemtoReg;
    logic       IRWrite;
    logic       ALUSrcA;
    logic       RegWrite;
    logic       RegDst;
    logic [1:0] ALUOp;
    logic [1:0] ALUSrcB;
    logic [1:0] PCSource;
    logic [3:0] State;

    // The controller is the master: it consumes Op and drives every strobe.
    modport master (
        input  Op,
        output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg,
               IRWrite, ALUSrcA, RegWrite, RegDst, ALUOp, ALUSrcB,
               PCSource, State
    );

    modport slave (
        output Op,
        input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg,
               IRWrite, ALUSrcA, RegWrite, RegDst, ALUOp, ALUSrcB,
               PCSource, State
    );
endinterface

`default_nettype wire

// File: rtl/multicycle_control.sv
// ============================================================================
//  Module      : multicycle_control
//  Description : Moore FSM sequencing a multi-cycle MIPS-style datapath.
//                Define MULTICYCLE_JUMP_EN to add the JUMP state for j.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module multicycle_control (
    input  wire                    clk,
    input  wire                    reset,
    multicycle_control_if.master   bus
);

    localparam logic [5:0] C_OP_LW   = 6'b100011;
    localparam logic [5:0] C_OP_SW   = 6'b101011;
    localparam logic [5:0] C_OP_RTYP = 6'b000000;
    localparam logic [5:0] C_OP_BEQ  = 6'b000100;
`ifdef MULTICYCLE_JUMP_EN
    localparam logic [5:0] C_OP_J    = 6'b000010;
`endif

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
`ifdef MULTICYCLE_JUMP_EN
        S_BEQ    = 4'd8,
        S_JUMP   = 4'd9
`else
        S_BEQ    = 4'd8
`endif
    } state_t;

    state_t state_q;
    state_t state_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d         = S_FETCH;
        bus.PCWrite     = 1'b0;
        bus.PCWriteCond = 1'b0;
        bus.IorD        = 1'b0;
        bus.MemRead     = 1'b0;
        bus.MemWrite    = 1'b0;
        bus.MemtoReg    = 1'b0;
        bus.IRWrite     = 1'b0;
        bus.ALUSrcA     = 1'b0;
        bus.RegWrite    = 1'b0;
        bus.RegDst      = 1'b0;
        bus.ALUOp       = 2'b00;
        bus.ALUSrcB     = 2'b00;
        bus.PCSource    = 2'b00;
        bus.State       = state_q;

        case (state_q)
            S_FETCH: begin
                bus.MemRead = 1'b1;
                bus.IRWrite = 1'b1;
                bus.ALUSrcB = 2'b01;
                bus.PCWrite = 1'b1;
                state_d     = S_DECODE;
            end
            S_DECODE: begin
                bus.ALUSrcB = 2'b11;
                case (bus.Op)
                    C_OP_LW, C_OP_SW: state_d = S_MEMADR;
                    C_OP_RTYP:        state_d = S_EXEC;
                    C_OP_BEQ:         state_d = S_BEQ;
`ifdef MULTICYCLE_JUMP_EN
                    C_OP_J:           state_d = S_JUMP;
`endif
                    default:          state_d = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = 2'b10;
                state_d     = (bus.Op == C_OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                bus.MemRead = 1'b1;
                bus.IorD    = 1'b1;
                state_d     = S_MEMWB;
            end
            S_MEMWB: begin
                bus.RegWrite = 1'b1;
                bus.MemtoReg = 1'b1;
                state_d      = S_FETCH;
            end
            S_MEMWR: begin
                bus.MemWrite = 1'b1;
                bus.IorD     = 1'b1;
                state_d      = S_FETCH;
            end
            S_EXEC: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUOp   = 2'b10;
                state_d     = S_RWB;
            end
            S_RWB: begin
                bus.RegWrite = 1'b1;
                bus.RegDst   = 1'b1;
                state_d      = S_FETCH;
            end
            S_BEQ: begin
                bus.ALUSrcA     = 1'b1;
                bus.ALUOp       = 2'b01;
                bus.PCWriteCond = 1'b1;
                bus.PCSource    = 2'b01;
                state_d         = S_FETCH;
            end
`ifdef MULTICYCLE_JUMP_EN
            S_JUMP: begin
                bus.PCWrite  = 1'b1;
                bus.PCSource = 2'b10;
                state_d      = S_FETCH;
            end
`endif
            // Unused encodings recover to FETCH with every strobe idle.
            default: begin
                state_d = S_FETCH;
            end
        endcase

        // Reset blanks the outputs immediately, not just after the next edge.
        if (reset) begin
            bus.PCWrite     = 1'b0;
            bus.PCWriteCond = 1'b0;
            bus.IorD        = 1'b0;
            bus.MemRead     = 1'b0;
            bus.MemWrite    = 1'b0;
            bus.MemtoReg    = 1'b0;
            bus.IRWrite     = 1'b0;
            bus.ALUSrcA     = 1'b0;
            bus.RegWrite    = 1'b0;
            bus.RegDst      = 1'b0;
            bus.ALUOp       = 2'b00;
            bus.ALUSrcB     = 2'b00;
            bus.PCSource    = 2'b00;
            bus.State       = 4'd0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control.sv
// ============================================================================
//  Module      : tb_multicycle_control
//  Description : Directed vector bench for multicycle_control.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_multicycle_control;

    logic clk;
    logic reset;

    multicycle_control_if bus ();

    multicycle_control dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,MemtoReg,IRWrite,ALUSrcA,
    //  RegWrite,RegDst, ALUOp, ALUSrcB, PCSource, State}
    localparam logic [19:0] C_ZERO   = 20'h0;
    localparam logic [19:0] C_FETCH  = {10'b1001001000, 2'b00, 2'b01, 2'b00, 4'd0};
    localparam logic [19:0] C_DECODE = {10'b0000000000, 2'b00, 2'b11, 2'b00, 4'd1};
    localparam logic [19:0] C_MEMADR = {10'b0000000100, 2'b00, 2'b10, 2'b00, 4'd2};
    localparam logic [19:0] C_MEMRD  = {10'b0011000000, 2'b00, 2'b00, 2'b00, 4'd3};
    localparam logic [19:0] C_MEMWB  = {10'b0000010010, 2'b00, 2'b00, 2'b00, 4'd4};
    localparam logic [19:0] C_MEMWR  = {10'b0010100000, 2'b00, 2'b00, 2'b00, 4'd5};
    localparam logic [19:0] C_EXEC   = {10'b0000000100, 2'b10, 2'b00, 2'b00, 4'd6};
    localparam logic [19:0] C_RWB    = {10'b0000000011, 2'b00, 2'b00, 2'b00, 4'd7};
    localparam logic [19:0] C_BEQ    = {10'b0100000100, 2'b01, 2'b00, 2'b01, 4'd8};
    localparam logic [19:0] C_JUMP   = {10'b1000000000, 2'b00, 2'b00, 2'b10, 4'd9};

    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_R   = 6'b000000;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_J   = 6'b000010;
    localparam logic [5:0] OP_BAD = 6'b111111;

    typedef struct {
        logic        rst;
        logic [5:0]  op;
        logic [19:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[$];
    int   passed;
    int   total;

    function automatic logic [19:0] pack_outputs();
        return {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead,
                bus.MemWrite, bus.MemtoReg, bus.IRWrite, bus.ALUSrcA,
                bus.RegWrite, bus.RegDst, bus.ALUOp, bus.ALUSrcB,
                bus.PCSource, bus.State};
    endfunction

    task automatic add(input logic r, input logic [5:0] op,
                       input logic [19:0] exp, input string name);
        vec_t v;
        v.rst  = r;
        v.op   = op;
        v.exp  = exp;
        v.name = name;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [19:0] got,
                         input logic [19:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %05h expected %05h", name, got, exp);
    endtask

    initial begin
        logic [19:0] got;
        passed   = 0;
        total    = 0;
        reset    = 1'b1;
        bus.Op   = OP_LW;

        // Each record: inputs held for one cycle, outputs expected in that cycle.
        add(1, OP_LW,  C_ZERO,   "rst0");
        add(1, OP_LW,  C_ZERO,   "rst1");
        add(0, OP_LW,  C_FETCH,  "lw_fetch");
        add(0, OP_LW,  C_DECODE, "lw_decode");
        add(0, OP_LW,  C_MEMADR, "lw_memadr");
        add(0, OP_R,   C_MEMRD,  "lw_memrd_opchg");
        add(0, OP_R,   C_MEMWB,  "lw_memwb");
        add(0, OP_SW,  C_FETCH,  "sw_fetch");
        add(0, OP_SW,  C_DECODE, "sw_decode");
        add(0, OP_SW,  C_MEMADR, "sw_memadr");
        add(0, OP_BAD, C_MEMWR,  "sw_memwr_opchg");
        add(0, OP_R,   C_FETCH,  "r_fetch");
        add(0, OP_R,   C_DECODE, "r_decode");
        add(0, OP_BEQ, C_EXEC,   "r_exec_opchg");
        add(0, OP_BEQ, C_RWB,    "r_rwb");
        add(0, OP_BEQ, C_FETCH,  "beq_fetch");
        add(0, OP_BEQ, C_DECODE, "beq_decode");
        add(0, OP_J,   C_BEQ,    "beq_exec");
        add(0, OP_J,   C_FETCH,  "j_fetch");
        add(0, OP_J,   C_DECODE, "j_decode");
`ifdef MULTICYCLE_JUMP_EN
        add(0, OP_J,   C_JUMP,   "j_jump");
`endif
        add(0, OP_BAD, C_FETCH,  "bad_fetch");
        add(0, OP_BAD, C_DECODE, "bad_decode");
        // Reset mid-store: strobes blank at once and stay blank after the edge.
        add(0, OP_SW,  C_FETCH,  "rsw_fetch");
        add(0, OP_SW,  C_DECODE, "rsw_decode");
        add(0, OP_SW,  C_MEMADR, "rsw_memadr");
        add(0, OP_SW,  C_MEMWR,  "rsw_memwr");
        add(1, OP_SW,  C_ZERO,   "rsw_reset_in_memwr");
        add(1, OP_SW,  C_ZERO,   "rsw_reset_after_edge");
        add(0, OP_BAD, C_FETCH,  "rsw_refetch");
        add(0, OP_BAD, C_DECODE, "rsw_decode2");
        add(0, OP_BAD, C_FETCH,  "rsw_dropped");

        @(negedge clk);
        for (int i = 0; i < vecs.size(); i++) begin
            reset  = vecs[i].rst;
            bus.Op = vecs[i].op;
            #1;
            got = pack_outputs();
            check(vecs[i].name, got, vecs[i].exp);
            total++;
            if (!(bus.MemWrite && bus.RegWrite)) passed++;
            else $display("FAIL %s_wr_excl: MemWrite=%0b RegWrite=%0b required not both 1",
                          vecs[i].name, bus.MemWrite, bus.RegWrite);
            @(negedge clk);
        end

        // Jump build never uses PCSource=10 outside JUMP; disabled build never at all.
        reset  = 1'b0;
        bus.Op = OP_J;
        for (int c = 0; c < 4; c++) begin
            #1;
            total++;
`ifdef MULTICYCLE_JUMP_EN
            if (bus.PCSource != 2'b10 || bus.State == 4'd9) passed++;
`else
            if (bus.PCSource != 2'b10) passed++;
`endif
            else $display("FAIL pcsrc_jump: PCSource=%b State=%0d", bus.PCSource, bus.State);
            @(negedge clk);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
- REQ-001: The block SHALL have one clock and a synchronous, active-high reset.
- REQ-002: clk  input  1  rising-edge clock; all state changes occur on it.
- REQ-003: reset  input  1  synchronous, active-high reset.
- REQ-004: Op  input  6  opcode field, Instruction[31:26], taken from the instruction register.
- REQ-005: PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite, ALUSrcA, RegWrite, RegDst  output  1 each  datapath strobes and mux selects.
- REQ-006: ALUOp  output  2  00=add, 01=sub, 10=funct; feeds ALUcontrol.
- REQ-007: ALUSrcB  output  2  00=reg B, 01=constant 4, 10=sign-extended imm, 11=sign-extended imm<<2.
- REQ-008: PCSource  output  2  00=ALU result, 01=ALUOut, 10=jump target.
- REQ-009: State  output  4  current state encoding, for debug.

Function
- REQ-010: The block SHALL be a Moore FSM; every output SHALL decode from the registered state only, with no Op-to-output combinational path.
- REQ-011: States and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RWB=7, BEQ=8, JUMP=9.
- REQ-012: FETCH: MemRead=1, IRWrite=1, ALUSrcB=01, ALUOp=00, PCWrite=1, PCSource=00; next state DECODE.
- REQ-013: DECODE: ALUSrcB=11, ALUOp=00; next state by Op: 100011/101011->MEMADR, 000000->EXEC, 000100->BEQ, 000010->JUMP (see REQ-022), any other value->FETCH (instruction dropped).
- REQ-014: MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00; next state MEMRD if Op=100011, otherwise MEMWR.
- REQ-015: MEMRD: MemRead=1, IorD=1; next state MEMWB.
- REQ-016: MEMWB: RegWrite=1, MemtoReg=1, RegDst=0; next state FETCH.
- REQ-017: MEMWR: MemWrite=1, IorD=1; next state FETCH.
- REQ-018: EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10; next state RWB.
- REQ-019: RWB: RegWrite=1, RegDst=1, MemtoReg=0; next state FETCH.
- REQ-020: BEQ: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01; next state FETCH.
- REQ-021: Any output not listed for a state SHALL be 0.
- REQ-022: Cycle counts per instruction: lw 5, sw 4, R-type 4, beq 3, j 3, unsupported 2.
- REQ-023: Op SHALL be sampled only in DECODE and MEMADR; changes in Op in other states SHALL have no effect.
- REQ-024: An unreachable encoding (10-15) SHALL go to FETCH on the next edge, with all outputs 0 while in it.
- REQ-025: MemWrite and RegWrite SHALL never be 1 in the same cycle.

Reset
- REQ-026: reset=1 at a rising edge SHALL load FETCH, taking priority over any transition, including mid-instruction (for example in MEMWR).
- REQ-027: While reset=1, all outputs SHALL be forced to 0 and State SHALL read 0.
- REQ-028: On the first edge after reset deasserts, the FETCH strobes SHALL be active for exactly one cycle before DECODE.

Configuration
- REQ-029: The macro MULTICYCLE_JUMP_EN SHALL control jump support.
- REQ-030: With MULTICYCLE_JUMP_EN defined: Op=000010 in DECODE SHALL go to JUMP, which drives PCWrite=1 and PCSource=10, then returns to FETCH.
- REQ-031: Without MULTICYCLE_JUMP_EN: the JUMP state SHALL be absent, Op=000010 SHALL be treated as unsupported, and PCSource SHALL never equal 10.

Verification
- REQ-032: Reset for 2 cycles, then release with Op=100011 -> State sequence 0,1,2,3,4,0; RegWrite=1 and MemtoReg=1 only in state 4.
- REQ-033: Op=101011 -> State sequence 0,1,2,5,0; MemWrite=1 for exactly one cycle with IorD=1.
- REQ-034: Op=000000 -> State sequence 0,1,6,7,0; ALUOp=10 in state 6; RegDst=1 and RegWrite=1 in state 7.
- REQ-035: Op=000100 -> State sequence 0,1,8,0; ALUOp=01, PCWriteCond=1, PCSource=01 in state 8. Op=000010 with the macro defined -> sequence 0,1,9,0 with PCSource=10; without the macro -> 0,1,0.
- REQ-036: Op=111111 -> State sequence 0,1,0 with no RegWrite or MemWrite pulse.
- REQ-037: Assert reset while in state 5 -> next edge gives State=0 and all outputs 0; MemWrite is not held.
